// File: rtl/scan_display_decoder_if.sv
// Bundles the seven-segment scan bus and the decoder's results.
//   an[7:0]          anode enables as they appear on the pins
//   seg[6:0]         cathodes as they appear on the pins, seg[0]=a .. seg[6]=g
//   frame_data[31:0] last good frame, digit k at [4k+3:4k]
//   frame_bad[7:0]   bit k set = digit k was not a legal hex glyph
//   frame_valid      one-cycle pulse when frame_data/frame_bad update
//   err_onehot       one-cycle pulse: more than one anode active
//   err_seq          one-cycle pulse: scan order or dwell violated
//   sync             high while the decoder is locked onto the scan
//   frame_count      number of frames published (wraps)
// master: the side driving the display bus; slave: the decoder.
interface scan_display_decoder_if;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] frame_data;
  logic [7:0]  frame_bad;
  logic        frame_valid;
  logic        err_onehot;
  logic        err_seq;
  logic        sync;
  logic [15:0] frame_count;

  modport master (
    output an, seg,
    input  frame_data, frame_bad, frame_valid, err_onehot, err_seq, sync, frame_count
  );

  modport slave (
    input  an, seg,
    output frame_data, frame_bad, frame_valid, err_onehot, err_seq, sync, frame_count
  );
endinterface

// File: rtl/scan_display_decoder.sv
// Monitors a multiplexed 8-digit seven-segment bus and rebuilds the hex
// digits being shown. Each anode must be held for DWELL clocks and the
// anodes must be scanned 0,1,..,7 in order; every complete frame is
// published as a 32-bit word together with a per-digit "bad glyph" mask.
// Ports:
//   clk_480Hz  scan clock, all logic on the rising edge
//   reset      synchronous, active-high
//   bus        slave side of scan_display_decoder_if (see that file)
// Parameters:
//   DWELL          clocks each anode stays active (1..15)
//   AN_ACTIVE_LOW  anode pins active-low when 1
//   SEG_ACTIVE_LOW cathode pins active-low when 1
module scan_display_decoder #(
  parameter int DWELL          = 1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_480Hz,
  input  logic                  reset,
  scan_display_decoder_if.slave bus
);

  localparam logic [3:0]  DWELL_W   = 4'(DWELL);
  localparam logic [7:0]  AN_FLIP   = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [6:0]  SEG_FLIP  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  // Bit b of the anode index is the OR of all anode lines whose position has bit b set.
  localparam logic [23:0] IDX_MASKS = {8'hF0, 8'hCC, 8'hAA};

  typedef enum logic {HUNT, TRACK} state_t;

  // Input stage, normalised to active-high. Cleared to "blank" on reset.
  logic [7:0] an_q;
  logic [6:0] seg_q;

  always_ff @(posedge clk_480Hz) begin
    if (reset) begin
      an_q  <= 8'h00;
      seg_q <= 7'h00;
    end else begin
      an_q  <= bus.an ^ AN_FLIP;
      seg_q <= bus.seg ^ SEG_FLIP;
    end
  end

  // Anode classification
  logic       an_blank;
  logic       an_multi;
  logic [2:0] an_idx;

  assign an_blank = (an_q == 8'h00);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign an_multi = ((an_q & (an_q - 8'd1)) != 8'h00);

  // Only meaningful when exactly one anode is active.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_idx
      assign an_idx[gi] = |(an_q & IDX_MASKS[8*gi +: 8]);
    end
  endgenerate

  // Glyph decode (gfedcba, active-high)
  logic [3:0] glyph_nib;
  logic       glyph_bad;

  always_comb begin
    glyph_nib = 4'h0;
    glyph_bad = 1'b0;
    case (seg_q)
      7'h3F: glyph_nib = 4'h0;
      7'h06: glyph_nib = 4'h1;
      7'h5B: glyph_nib = 4'h2;
      7'h4F: glyph_nib = 4'h3;
      7'h66: glyph_nib = 4'h4;
      7'h6D: glyph_nib = 4'h5;
      7'h7D: glyph_nib = 4'h6;
      7'h07: glyph_nib = 4'h7;
      7'h7F: glyph_nib = 4'h8;
      7'h6F: glyph_nib = 4'h9;
      7'h77: glyph_nib = 4'hA;
      7'h7C: glyph_nib = 4'hB;
      7'h39: glyph_nib = 4'hC;
      7'h5E: glyph_nib = 4'hD;
      7'h79: glyph_nib = 4'hE;
      7'h71: glyph_nib = 4'hF;
      default: glyph_bad = 1'b1;
    endcase
  end

  // Scan tracker
  state_t      state_reg, state_next;
  logic [2:0]  cur_reg, cur_next;
  logic [3:0]  dwell_reg, dwell_next;
  logic [31:0] data_buf_reg;
  logic [7:0]  bad_buf_reg;
  logic [31:0] frame_data_reg;
  logic [7:0]  frame_bad_reg;
  logic        frame_valid_reg;
  logic        err_onehot_reg;
  logic        err_seq_reg;
  logic        sync_reg;
  logic [15:0] frame_count_reg;

  logic accept;      // sample is a legal continuation of the scan
  logic capture;     // sample is the last dwell cycle of digit cur_next
  logic complete;    // sample finishes digit 7
  logic onehot_err;
  logic seq_err;

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    dwell_next = dwell_reg;
    accept     = 1'b0;
    onehot_err = 1'b0;
    seq_err    = 1'b0;
    case (state_reg)
      HUNT: begin
        if (an_multi) begin
          onehot_err = 1'b1;
        end else if (!an_blank && an_idx == 3'd0) begin
          state_next = TRACK;
          cur_next   = 3'd0;
          dwell_next = 4'd1;
          accept     = 1'b1;
        end
      end
      TRACK: begin
        if (an_multi) begin
          onehot_err = 1'b1;
          state_next = HUNT;
        end else if (an_blank) begin
          state_next = HUNT;
        end else if (an_idx == cur_reg) begin
          if (dwell_reg < DWELL_W) begin
            dwell_next = dwell_reg + 4'd1;
            accept     = 1'b1;
          end else begin
            seq_err    = 1'b1;
            state_next = HUNT;
          end
        // cur_reg is 3 bits, so after digit 7 the expected next index wraps
        // to 0 and a continuous scan stays in TRACK across frame boundaries.
        end else if (an_idx == cur_reg + 3'd1 && dwell_reg == DWELL_W) begin
          cur_next   = an_idx;
          dwell_next = 4'd1;
          accept     = 1'b1;
        end else begin
          seq_err = 1'b1;
          if (an_idx == 3'd0) begin
            // A digit-0 sample is a valid frame start, so relock on it.
            state_next = TRACK;
            cur_next   = 3'd0;
            dwell_next = 4'd1;
            accept     = 1'b1;
          end else begin
            state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign capture  = accept && (dwell_next == DWELL_W);
  assign complete = capture && (cur_next == 3'd7);

  always_ff @(posedge clk_480Hz) begin
    if (reset) begin
      state_reg       <= HUNT;
      cur_reg         <= 3'd0;
      dwell_reg       <= 4'd0;
      data_buf_reg    <= 32'h0;
      bad_buf_reg     <= 8'h0;
      frame_data_reg  <= 32'h0;
      frame_bad_reg   <= 8'h0;
      frame_valid_reg <= 1'b0;
      err_onehot_reg  <= 1'b0;
      err_seq_reg     <= 1'b0;
      sync_reg        <= 1'b0;
      frame_count_reg <= 16'h0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      dwell_reg      <= dwell_next;
      err_onehot_reg <= onehot_err;
      err_seq_reg    <= seq_err;
      sync_reg       <= (state_next == TRACK);
      if (capture) begin
        data_buf_reg[{cur_next, 2'b00} +: 4] <= glyph_nib;
        bad_buf_reg[cur_next]                <= glyph_bad;
      end
      // Digit 7 is still being captured this cycle, so take it directly
      // from the decoder rather than from the buffer.
      frame_valid_reg <= complete;
      if (complete) begin
        frame_data_reg  <= {glyph_nib, data_buf_reg[27:0]};
        frame_bad_reg   <= {glyph_bad, bad_buf_reg[6:0]};
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  assign bus.frame_data  = frame_data_reg;
  assign bus.frame_bad   = frame_bad_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.err_onehot  = err_onehot_reg;
  assign bus.err_seq     = err_seq_reg;
  assign bus.sync        = sync_reg;
  assign bus.frame_count = frame_count_reg;

endmodule
